// File: rtl/adder_pipe_if.sv
// adder_pipe_if: operand/result handshake bundle for adder_pipe
interface adder_pipe_if #(parameter int WIDTH = 128);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din_one;
  logic [WIDTH-1:0] din_two;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master (output in_valid, din_one, din_two, cin, sub, out_ready,
                  input in_ready, out_valid, sum, cout, ovf);
  modport slave (input in_valid, din_one, din_two, cin, sub, out_ready,
                 output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/adder_pipe.sv
// adder_pipe: segmented pipelined add/subtract with valid/ready; define ADDER_PIPE_OVF_EN for signed overflow
module adder_pipe #(
  parameter int WIDTH = 128,
  parameter int SEG_W = 32
) (
  input logic        clk,
  input logic        rst,
  adder_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / SEG_W;
  logic advance;
  assign advance = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // stage k sees only the operand bits it and later stages still need
    localparam int SRC_W = WIDTH - k * SEG_W;
    logic                   v_in;
    logic                   ci_in;
    logic [SRC_W-1:0]       a_in;
    logic [SRC_W-1:0]       b_in;
    logic [SEG_W:0]         r;
    logic [(k+1)*SEG_W-1:0] s_d;
    logic [(k+1)*SEG_W-1:0] s_q;
    logic                   v_q;
    logic                   c_q;
    assign r = {1'b0, a_in[SEG_W-1:0]} + {1'b0, b_in[SEG_W-1:0]} + (SEG_W+1)'(ci_in);
    if (k == 0) begin : g_head
      assign v_in  = bus.in_valid;
      assign ci_in = bus.cin ^ bus.sub;
      assign a_in  = bus.din_one;
      assign b_in  = bus.din_two ^ {WIDTH{bus.sub}};
      assign s_d   = r[SEG_W-1:0];
    end else begin : g_body
      logic [SRC_W-1:0] a_q;
      logic [SRC_W-1:0] b_q;
      always_ff @(posedge clk)
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= g_stg[k-1].a_in[SRC_W+SEG_W-1:SEG_W];
          b_q <= g_stg[k-1].b_in[SRC_W+SEG_W-1:SEG_W];
        end
      assign v_in  = g_stg[k-1].v_q;
      assign ci_in = g_stg[k-1].c_q;
      assign a_in  = a_q;
      assign b_in  = b_q;
      assign s_d   = {r[SEG_W-1:0], g_stg[k-1].s_q};
    end
    always_ff @(posedge clk)
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= r[SEG_W];
        s_q <= s_d;
      end
    if (k == STAGES - 1) begin : g_tail
      assign bus.out_valid = v_q;
      assign bus.cout      = c_q;
      assign bus.sum       = s_q;
`ifdef ADDER_PIPE_OVF_EN
      // the operand sign bits reach the last stage through the skew registers
      logic ovf_q;
      always_ff @(posedge clk)
        if (rst) ovf_q <= 1'b0;
        else if (advance) ovf_q <= (a_in[SRC_W-1] == b_in[SRC_W-1]) && (r[SEG_W-1] != a_in[SRC_W-1]);
      assign bus.ovf = ovf_q;
`else
      assign bus.ovf = 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: table vectors plus scoreboarded streams across four (WIDTH,SEG_W) builds
module tb_adder_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  adder_pipe_if #(.WIDTH(128)) i0 ();
  adder_pipe_if #(.WIDTH(128)) i1 ();
  adder_pipe_if #(.WIDTH(64))  i2 ();
  adder_pipe_if #(.WIDTH(8))   i3 ();
  adder_pipe #(.WIDTH(128), .SEG_W(32))  d0 (.clk(clk), .rst(rst), .bus(i0.slave));
  adder_pipe #(.WIDTH(128), .SEG_W(128)) d1 (.clk(clk), .rst(rst), .bus(i1.slave));
  adder_pipe #(.WIDTH(64),  .SEG_W(16))  d2 (.clk(clk), .rst(rst), .bus(i2.slave));
  adder_pipe #(.WIDTH(8),   .SEG_W(1))   d3 (.clk(clk), .rst(rst), .bus(i3.slave));

  typedef struct {
    logic [127:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
    int           st;
  } exp_t;
  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic         ci;
    logic         sb;
    logic [127:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  exp_t         sbq[4][$];
  int           stalls[4];
  logic         held[4];
  logic [127:0] hsum[4];
  int           cyc = 0;
  int           errs = 0;
  int           checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [127:0] a, input logic [127:0] b,
                                 input logic ci, input logic sb);
    exp_t e;
    logic [128:0] m;
    logic [128:0] full;
    m = (129'd1 << w) - 129'd1;
    full = sb ? ({1'b0, a} - {1'b0, b} - 129'(ci)) : ({1'b0, a} + {1'b0, b} + 129'(ci));
    e.sum = full[127:0] & m[127:0];
    e.cout = sb ? ({1'b0, a} >= {1'b0, b} + 129'(ci)) : full[w];
    e.ovf = sb ? (a[w-1] != b[w-1] && e.sum[w-1] != a[w-1]) : (a[w-1] == b[w-1] && e.sum[w-1] != a[w-1]);
`ifndef ADDER_PIPE_OVF_EN
    e.ovf = 1'b0;
`endif
    e.acc = 0;
    e.st = 0;
    return e;
  endfunction

  task automatic mon(input int d, input int w, input int s, input logic iv, input logic ir,
                     input logic [127:0] a, input logic [127:0] b, input logic ci, input logic sb,
                     input logic ov, input logic orr, input logic [127:0] sm, input logic co, input logic of);
    exp_t e;
    if (rst) begin
      sbq[d].delete();
      held[d] = 1'b0;
      return;
    end
    if (ov && !orr) begin
      chk($sformatf("hold_in_ready_d%0d", d), {127'd0, ir}, 128'd0);
      if (held[d]) chk($sformatf("hold_sum_stable_d%0d", d), sm, hsum[d]);
      held[d] = 1'b1;
      hsum[d] = sm;
      stalls[d]++;
    end else held[d] = 1'b0;
    if (ov && orr) begin
      if (sbq[d].size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_result_d%0d: got sum %h expected no result", d, sm);
      end else begin
        e = sbq[d].pop_front();
        chk($sformatf("sb_sum_d%0d", d), sm, e.sum);
        chk($sformatf("sb_cout_d%0d", d), {127'd0, co}, {127'd0, e.cout});
        chk($sformatf("sb_ovf_d%0d", d), {127'd0, of}, {127'd0, e.ovf});
        chk($sformatf("sb_latency_d%0d", d), 128'(cyc + 1 - e.acc), 128'(s + stalls[d] - e.st));
      end
    end
    if (iv && ir) begin
      e = model(w, a, b, ci, sb);
      e.acc = cyc + 1;
      e.st = stalls[d];
      sbq[d].push_back(e);
    end
  endtask

  always @(negedge clk) begin
    mon(0, 128, 4, i0.in_valid, i0.in_ready, i0.din_one, i0.din_two, i0.cin, i0.sub,
        i0.out_valid, i0.out_ready, i0.sum, i0.cout, i0.ovf);
    mon(1, 128, 1, i1.in_valid, i1.in_ready, i1.din_one, i1.din_two, i1.cin, i1.sub,
        i1.out_valid, i1.out_ready, i1.sum, i1.cout, i1.ovf);
    mon(2, 64, 4, i2.in_valid, i2.in_ready, 128'(i2.din_one), 128'(i2.din_two), i2.cin, i2.sub,
        i2.out_valid, i2.out_ready, 128'(i2.sum), i2.cout, i2.ovf);
    mon(3, 8, 8, i3.in_valid, i3.in_ready, 128'(i3.din_one), 128'(i3.din_two), i3.cin, i3.sub,
        i3.out_valid, i3.out_ready, 128'(i3.sum), i3.cout, i3.ovf);
  end

  task automatic drive(input logic v, input logic [127:0] a, input logic [127:0] b,
                       input logic ci, input logic sb);
    i0.in_valid = v; i0.din_one = a;        i0.din_two = b;        i0.cin = ci; i0.sub = sb;
    i1.in_valid = v; i1.din_one = a;        i1.din_two = b;        i1.cin = ci; i1.sub = sb;
    i2.in_valid = v; i2.din_one = a[63:0];  i2.din_two = b[63:0];  i2.cin = ci; i2.sub = sb;
    i3.in_valid = v; i3.din_one = a[7:0];   i3.din_two = b[7:0];   i3.cin = ci; i3.sub = sb;
  endtask

  task automatic set_ordy(input logic r);
    i0.out_ready = r; i1.out_ready = r; i2.out_ready = r; i3.out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic apply_vec(input string n, input vec_t v);
    int k;
    drive(1'b1, v.a, v.b, v.ci, v.sb);
    set_ordy(1'b1);
    @(negedge clk);
    chk({n, "_in_ready"}, {127'd0, i0.in_ready}, 128'd1);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    k = 0;
    @(negedge clk);
    while (!i0.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({n, "_latency"}, 128'(k + 1), 128'd4);
    chk({n, "_sum"}, i0.sum, v.sum);
    chk({n, "_cout"}, {127'd0, i0.cout}, {127'd0, v.cout});
`ifdef ADDER_PIPE_OVF_EN
    chk({n, "_ovf"}, {127'd0, i0.ovf}, {127'd0, v.ovf});
`else
    chk({n, "_ovf"}, {127'd0, i0.ovf}, 128'd0);
`endif
    step();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0 && k < 100) begin
      step();
      k++;
    end
  endtask

  vec_t         vt[7];
  vec_t         rv;
  logic [127:0] ra[16];
  logic [127:0] rb[16];
  logic         rc[16];
  logic         rs[16];

  initial begin
    int i;
    int c;
    vt[0] = '{a: '1, b: 128'd0, ci: 1'b1, sb: 1'b0, sum: 128'd0, cout: 1'b1, ovf: 1'b0};
    vt[1] = '{a: 128'd5, b: 128'd7, ci: 1'b0, sb: 1'b1, sum: ~128'd1, cout: 1'b0, ovf: 1'b0};
    vt[2] = '{a: {1'b0, {127{1'b1}}}, b: 128'd1, ci: 1'b0, sb: 1'b0, sum: {1'b1, 127'd0}, cout: 1'b0, ovf: 1'b1};
    vt[3] = '{a: 128'd0, b: 128'd0, ci: 1'b1, sb: 1'b1, sum: '1, cout: 1'b0, ovf: 1'b0};
    vt[4] = '{a: {1'b1, 127'd0}, b: 128'd1, ci: 1'b0, sb: 1'b1, sum: {1'b0, {127{1'b1}}}, cout: 1'b1, ovf: 1'b1};
    vt[5] = '{a: 128'hFFFF_FFFF, b: 128'd1, ci: 1'b0, sb: 1'b0, sum: 128'h1_0000_0000, cout: 1'b0, ovf: 1'b0};
    vt[6] = '{a: 128'd10, b: 128'd3, ci: 1'b1, sb: 1'b1, sum: 128'd6, cout: 1'b1, ovf: 1'b0};
    for (int j = 0; j < 16; j++) begin
      ra[j] = rnd128();
      rb[j] = rnd128();
      rc[j] = 1'($urandom_range(1));
      rs[j] = 1'($urandom_range(1));
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    set_ordy(1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {127'd0, i0.out_valid}, 128'd0);
    chk("rst_sum", i0.sum, 128'd0);
    chk("rst_cout", {127'd0, i0.cout}, 128'd0);
    chk("rst_ovf", {127'd0, i0.ovf}, 128'd0);
    chk("rst_in_ready", {127'd0, i0.in_ready}, 128'd1);
    chk("rst_out_valid_d3", {127'd0, i3.out_valid}, 128'd0);
    step();
    for (int j = 0; j < 7; j++) apply_vec($sformatf("vec%0d", j), vt[j]);
    drain();
    // back-to-back stream with a five-cycle output hold starting at stream cycle 6
    i = 0;
    c = 0;
    while (i < 16 && c < 100) begin
      drive(1'b1, ra[i], rb[i], rc[i], rs[i]);
      set_ordy(!(c >= 6 && c < 11));
      @(negedge clk);
      if (i0.in_ready) i++;
      step();
      c++;
    end
    chk("stream_all_accepted", 128'(i), 128'd16);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    set_ordy(1'b1);
    drain();
    for (int j = 0; j < 4; j++) chk($sformatf("stream_drained_d%0d", j), 128'(sbq[j].size()), 128'd0);
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, rnd128(), rnd128(), 1'($urandom_range(1)), 1'($urandom_range(1)));
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      step();
    end
    drain();
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, rnd128(), rnd128(), 1'b0, 1'b0);
      step();
    end
    rst = 1'b1;
    drive(1'b1, 128'd9, 128'd9, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("flush_out_valid", {127'd0, i0.out_valid}, 128'd0);
      step();
    end
    rv = '{a: 128'd1, b: 128'd2, ci: 1'b0, sb: 1'b0, sum: 128'd3, cout: 1'b0, ovf: 1'b0};
    apply_vec("post_rst", rv);
    drain();
    for (int j = 0; j < 4; j++) chk($sformatf("final_drained_d%0d", j), 128'(sbq[j].size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
